// File: rtl/seq_window_match.sv
// Streaming sliding-window matcher: shifts symbols into a SEQ_WIDTH-symbol
// window, compares each full window against a latched pattern on the
// positions enabled by the mask, and reports windows whose masked mismatch
// count is within the threshold. Two-stage pipeline: per-position mismatch
// flags, then popcount and threshold compare.
module seq_window_match #(
  parameter int SEQ_WIDTH = 20,
  parameter int SYM_WIDTH = 2,
  parameter int POS_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [SEQ_WIDTH*SYM_WIDTH-1:0]     i_pattern,
  input  logic [SEQ_WIDTH-1:0]               i_mask,
  input  logic [$clog2(SEQ_WIDTH+1)-1:0]     i_max_mism,
  input  logic                               i_valid,
  input  logic [SYM_WIDTH-1:0]               i_sym,
  input  logic                               i_last,
  output logic                               o_ready,
  output logic                               o_busy,
  output logic                               o_match_valid,
  output logic [POS_WIDTH-1:0]               o_match_pos,
  output logic [$clog2(SEQ_WIDTH+1)-1:0]     o_mismatches,
  output logic [POS_WIDTH-1:0]               o_match_count,
  output logic                               o_done
);

  localparam int CNT_WIDTH = $clog2(SEQ_WIDTH + 1);
  localparam int WIN_WIDTH = SEQ_WIDTH * SYM_WIDTH;
  localparam logic [CNT_WIDTH-1:0] FILL_FULL = CNT_WIDTH'(SEQ_WIDTH);
  localparam logic [CNT_WIDTH-1:0] FILL_LAST = CNT_WIDTH'(SEQ_WIDTH - 1);
  localparam logic [POS_WIDTH-1:0] POS_BACK  = POS_WIDTH'(SEQ_WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [WIN_WIDTH-1:0] pat_q, pat_d;
  logic [SEQ_WIDTH-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0] thr_q, thr_d;
  logic [WIN_WIDTH-1:0] win_q, win_d;
  logic [CNT_WIDTH-1:0] fill_q, fill_d;
  logic [POS_WIDTH-1:0] sym_idx_q, sym_idx_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [SEQ_WIDTH-1:0] s1_mism_q, s1_mism_d;
  logic [POS_WIDTH-1:0] s1_pos_q, s1_pos_d;
  logic                 s2_valid_q, s2_valid_d;
  logic                 match_valid_q, match_valid_d;
  logic [POS_WIDTH-1:0] match_pos_q, match_pos_d;
  logic [CNT_WIDTH-1:0] mismatches_q, mismatches_d;
  logic [POS_WIDTH-1:0] match_count_q, match_count_d;

  logic                 start_search;
  logic                 accept;
  logic                 win_full;
  logic [CNT_WIDTH-1:0] mism_cnt;

  assign start_search = (state_q == ST_IDLE) && i_start;
  assign accept       = (state_q == ST_SCAN) && i_valid;
  // The window being shifted in is full once the previous fill was SEQ_WIDTH-1 or more.
  assign win_full     = accept && (fill_q >= FILL_LAST);

  // Control FSM: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    thr_d   = thr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SCAN;
          pat_d   = i_pattern;
          mask_d  = i_mask;
          thr_d   = i_max_mism;
        end
      end
      ST_SCAN:  if (accept && i_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Window shift register, saturating fill counter and stream index.
  always_comb begin
    win_d     = win_q;
    fill_d    = fill_q;
    sym_idx_d = sym_idx_q;
    if (start_search) begin
      fill_d    = '0;
      sym_idx_d = '0;
    end else if (accept) begin
      win_d     = {i_sym, win_q[WIN_WIDTH-1:SYM_WIDTH]};
      sym_idx_d = sym_idx_q + 1'b1;
      if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
    end
  end

  // Stage 1: per-position masked mismatch flags and window start position.
  always_comb begin
    s1_valid_d = win_full;
    s1_mism_d  = s1_mism_q;
    s1_pos_d   = s1_pos_q;
    if (win_full) begin
      for (int k = 0; k < SEQ_WIDTH; k++) begin
        s1_mism_d[k] = mask_q[k] &&
                       (win_d[k*SYM_WIDTH +: SYM_WIDTH] != pat_q[k*SYM_WIDTH +: SYM_WIDTH]);
      end
      s1_pos_d = sym_idx_q - POS_BACK;
    end
  end

  // Stage 2: popcount, threshold compare and result/counter update.
  always_comb begin
    mism_cnt = '0;
    for (int k = 0; k < SEQ_WIDTH; k++) begin
      mism_cnt = mism_cnt + CNT_WIDTH'(s1_mism_q[k]);
    end
    s2_valid_d    = s1_valid_q;
    match_valid_d = s1_valid_q && (mism_cnt <= thr_q);
    match_pos_d   = match_pos_q;
    mismatches_d  = mismatches_q;
    match_count_d = match_count_q;
    if (start_search) begin
      match_count_d = '0;
    end else if (match_valid_d) begin
      match_pos_d  = s1_pos_q;
      mismatches_d = mism_cnt;
      if (!(&match_count_q)) match_count_d = match_count_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q       <= ST_IDLE;
      pat_q         <= '0;
      mask_q        <= '0;
      thr_q         <= '0;
      // NOTE: the window is a plain flop shift register, not a RAM, so clearing it on reset is legal and cheap.
      win_q         <= '0;
      fill_q        <= '0;
      sym_idx_q     <= '0;
      s1_valid_q    <= 1'b0;
      s1_mism_q     <= '0;
      s1_pos_q      <= '0;
      s2_valid_q    <= 1'b0;
      match_valid_q <= 1'b0;
      match_pos_q   <= '0;
      mismatches_q  <= '0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      mask_q        <= mask_d;
      thr_q         <= thr_d;
      win_q         <= win_d;
      fill_q        <= fill_d;
      sym_idx_q     <= sym_idx_d;
      s1_valid_q    <= s1_valid_d;
      s1_mism_q     <= s1_mism_d;
      s1_pos_q      <= s1_pos_d;
      s2_valid_q    <= s2_valid_d;
      match_valid_q <= match_valid_d;
      match_pos_q   <= match_pos_d;
      mismatches_q  <= mismatches_d;
      match_count_q <= match_count_d;
    end
  end

  assign o_ready       = (state_q == ST_SCAN);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_match_valid = match_valid_q;
  assign o_match_pos   = match_pos_q;
  assign o_mismatches  = mismatches_q;
  assign o_match_count = match_count_q;

endmodule

// File: tb/tb_seq_window_match.sv
// Randomised bench for seq_window_match with a reference model that keeps the
// raw symbol history and recomputes each full window's masked mismatch count.
module tb_seq_window_match;

  localparam int SW = 20;
  localparam int YW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [SW*YW-1:0]  i_pattern;
  logic [SW-1:0]     i_mask;
  logic [4:0]        i_max_mism;
  logic              i_valid;
  logic [YW-1:0]     i_sym;
  logic              i_last;
  logic              o_ready;
  logic              o_busy;
  logic              o_match_valid;
  logic [15:0]       o_match_pos;
  logic [4:0]        o_mismatches;
  logic [15:0]       o_match_count;
  logic              o_done;

  seq_window_match #(.SEQ_WIDTH(SW), .SYM_WIDTH(YW), .POS_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_pattern(i_pattern), .i_mask(i_mask),
    .i_max_mism(i_max_mism), .i_valid(i_valid), .i_sym(i_sym), .i_last(i_last),
    .o_ready(o_ready), .o_busy(o_busy), .o_match_valid(o_match_valid),
    .o_match_pos(o_match_pos), .o_mismatches(o_mismatches),
    .o_match_count(o_match_count), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state
  typedef struct { int cyc; int pos; int mism; } exp_t;
  exp_t       exp_q[$];
  int         m_hist[$];
  int         m_pat[SW];
  logic [SW-1:0] m_mask;
  int         m_thr;
  int         m_idx;
  int         m_count;
  bit         m_busy = 0;
  bit         m_scan = 0;
  int         m_done_cyc = -1;
  int         m_last_eval = -100;
  int         cyc = 0;
  int         done_cnt = 0;
  bit         exp_now;
  int         stim_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor + model, sampled on the falling edge; cyc = rising edges so far.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_hist.delete();
      m_busy      = 0;
      m_scan      = 0;
      m_done_cyc  = -1;
      m_last_eval = -100;
    end else begin
      exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (o_match_valid || exp_now) begin
        check("match_valid", o_match_valid, exp_now);
        if (o_match_valid && exp_now) begin
          check("match_pos", o_match_pos, exp_q[0].pos);
          check("mismatches", o_mismatches, exp_q[0].mism);
        end
        if (exp_now) void'(exp_q.pop_front());
      end
      check("busy", o_busy, m_busy);
      check("ready", o_ready, m_scan);
      if (o_done || cyc == m_done_cyc) begin
        check("done", o_done, cyc == m_done_cyc);
        if (o_done) done_cnt++;
        if (cyc == m_done_cyc) check("match_count", o_match_count, m_count);
      end
      if (i_start && !m_busy) begin
        for (int k = 0; k < SW; k++) m_pat[k] = int'(i_pattern[k*YW +: YW]);
        m_mask  = i_mask;
        m_thr   = int'(i_max_mism);
        m_idx   = 0;
        m_count = 0;
        m_hist.delete();
        m_busy  = 1;
        m_scan  = 1;
        m_last_eval = -100;
      end else if (i_valid && m_scan) begin
        m_hist.push_back(int'(i_sym));
        if (m_hist.size() > SW) void'(m_hist.pop_front());
        if (m_hist.size() == SW) begin
          int mm;
          mm = 0;
          for (int k = 0; k < SW; k++)
            if (m_mask[k] && m_hist[k] != m_pat[k]) mm++;
          m_last_eval = cyc + 1;
          if (mm <= m_thr) begin
            exp_q.push_back('{cyc: cyc + 2, pos: (m_idx - (SW - 1)) & 16'hFFFF, mism: mm});
            if (m_count < 16'hFFFF) m_count++;
          end
        end
        m_idx++;
        if (i_last) begin
          // Done follows once the pipeline has emptied after the last accept.
          m_scan     = 0;
          m_done_cyc = (cyc + 2 > m_last_eval + 3) ? cyc + 2 : m_last_eval + 3;
        end
      end
      if (cyc == m_done_cyc) m_busy = 0;
    end
  end

  task automatic do_start(input logic [SW*YW-1:0] pat, input logic [SW-1:0] mask,
                          input logic [4:0] thr);
    @(posedge clk); #1;
    i_start = 1; i_pattern = pat; i_mask = mask; i_max_mism = thr;
    @(posedge clk); #1;
    i_start = 0;
  endtask

  // gap_pct < 0: one idle cycle between symbols; otherwise random gap percentage.
  task automatic send_syms(input int gap_pct, input int busy_start_at, input bit with_last,
                           input int n);
    for (int i = 0; i < n; i++) begin
      if (gap_pct < 0 && i > 0) begin
        i_valid = 0; @(posedge clk); #1;
      end
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        i_valid = 0; @(posedge clk); #1;
      end
      i_valid = 1;
      i_sym   = YW'(stim_q[i]);
      i_last  = with_last && (i == n - 1);
      i_start = (i == busy_start_at);
      if (i == busy_start_at) i_pattern = ~i_pattern;
      @(posedge clk); #1;
    end
    i_valid = 0; i_last = 0; i_start = 0;
  endtask

  task automatic run_search(input logic [SW*YW-1:0] pat, input logic [SW-1:0] mask,
                            input logic [4:0] thr, input int gap_pct, input int exp_count,
                            input int busy_start_at);
    int d0;
    d0 = done_cnt;
    do_start(pat, mask, thr);
    send_syms(gap_pct, busy_start_at, 1'b1, stim_q.size());
    for (int t = 0; t < 50 && done_cnt == d0; t++) @(posedge clk);
    check("done_seen", done_cnt - d0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    if (exp_count >= 0) check("hit_count", o_match_count, exp_count);
    check("pending", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mv"},    o_match_valid, 0);
    check({tag, "_pos"},   o_match_pos, 0);
    check({tag, "_mism"},  o_mismatches, 0);
    check({tag, "_count"}, o_match_count, 0);
    check({tag, "_done"},  o_done, 0);
    check({tag, "_ready"}, o_ready, 0);
    check({tag, "_busy"},  o_busy, 0);
  endtask

  logic [SW*YW-1:0] pat;
  logic [SW*YW-1:0] rnd;

  initial begin
    rst = 1; i_start = 0; i_pattern = '0; i_mask = '0; i_max_mism = '0;
    i_valid = 0; i_sym = '0; i_last = 0;
    repeat (4) @(posedge clk);
    #1 rst = 0;
    check_idle_outputs("reset");

    // Exact hit at stream index 3, contiguous then gapped
    pat = {$urandom, $urandom};
    for (int g = 0; g < 2; g++) begin
      stim_q.delete();
      for (int i = 0; i < 25; i++)
        stim_q.push_back((i >= 3 && i <= 22) ? int'(pat[(i-3)*YW +: YW]) : int'($urandom_range(3)));
      run_search(pat, 20'hFFFFF, 5'd0, g ? -1 : 0, 1, -1);
      check(g ? "gap_hit_pos" : "hit_pos", o_match_pos, 3);
      check(g ? "gap_hit_mism" : "hit_mism", o_mismatches, 0);
    end

    // Masked compare: only positions 0..7 agree
    stim_q.delete();
    for (int i = 0; i < SW; i++) begin
      logic [1:0] s;
      s = pat[i*YW +: YW];
      stim_q.push_back(i < 8 ? int'(s) : int'(s ^ 2'd1));
    end
    run_search(pat, 20'h000FF, 5'd0, 0, 1, -1);
    check("masked_pos", o_match_pos, 0);
    run_search(pat, 20'hFFFFF, 5'd0, 0, 0, -1);

    // Threshold: two mismatches at positions 5 and 12
    stim_q.delete();
    for (int i = 0; i < SW; i++) begin
      logic [1:0] s;
      s = pat[i*YW +: YW];
      stim_q.push_back((i == 5 || i == 12) ? int'(s ^ 2'd2) : int'(s));
    end
    run_search(pat, 20'hFFFFF, 5'd1, 0, 0, -1);
    run_search(pat, 20'hFFFFF, 5'd2, 0, 1, -1);
    check("thr_mism", o_mismatches, 2);

    // Short stream: no evaluations
    stim_q.delete();
    for (int i = 0; i < 10; i++) stim_q.push_back(int'($urandom_range(3)));
    run_search(pat, 20'hFFFFF, 5'd20, 25, 0, -1);

    // Reset mid-search after 15 symbols
    begin
      int d0;
      d0 = done_cnt;
      stim_q.delete();
      for (int i = 0; i < 30; i++) stim_q.push_back(int'($urandom_range(3)));
      do_start(pat, 20'hFFFFF, 5'd20);
      send_syms(0, -1, 1'b0, 15);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      check_idle_outputs("midrst");
      repeat (8) @(posedge clk);
      #1;
      check("midrst_no_done", done_cnt - d0, 0);
    end

    // Directed corners: all-zero mask, threshold >= SEQ_WIDTH, length-1 stream
    stim_q.delete();
    for (int i = 0; i < 30; i++) stim_q.push_back(int'($urandom_range(3)));
    run_search(pat, 20'h00000, 5'd0, 20, 11, -1);
    run_search(pat, 20'hFFFFF, 5'd20, 0, 11, 7);
    stim_q.delete();
    stim_q.push_back(1);
    run_search(pat, 20'hFFFFF, 5'd20, 0, 0, -1);

    // Randomised searches
    for (int r = 0; r < 10; r++) begin
      int len;
      len = $urandom_range(1, 70);
      rnd = {$urandom, $urandom};
      stim_q.delete();
      for (int i = 0; i < len; i++) stim_q.push_back(int'($urandom_range(3)));
      run_search(rnd, SW'($urandom), 5'($urandom_range(4, 20)), $urandom_range(0, 40), -1,
                 (r % 3 == 0) ? 2 : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
